// File: rtl/mtx_ls_seq.sv
// Matrix load/store sequencer: one issue expands into ELEMS word beats on the memory port.
// Beats advance on mem_ack, at most one per cycle; load data is written to the matrix register file on the ack cycle.
module mtx_ls_seq #(
   parameter int ELEMS = 16,
   parameter int CW    = $clog2(ELEMS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   output logic          issue_ready,
   input  logic          issue_store,
   input  logic [31:0]   issue_base,
   input  logic [31:0]   issue_imm,
   input  logic [2:0]    issue_mreg,
   input  logic          flush,
   output logic          mem_req,
   output logic          mem_we,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic [2:0]    mreg_idx,
   output logic [CW-1:0] mreg_elem,
   input  logic [31:0]   mreg_rdata,
   output logic          mreg_we,
   output logic [31:0]   mreg_wdata,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state;
   logic [31:0]   ea;
   logic          st_q;
   logic [2:0]    idx_q;
   logic [CW-1:0] cnt;
   logic          err_q;

   logic [31:0]   ea_next;
   logic          accept;
   logic          beat;
   logic          last;

   assign ea_next = issue_base + issue_imm;
   assign accept  = (state == IDLE) && issue_valid && !flush;
   assign beat    = (state == REQ) && mem_ack;
   assign last    = (cnt == CW'(ELEMS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ea    <= '0;
         st_q  <= 1'b0;
         idx_q <= '0;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ea    <= ea_next;
                  st_q  <= issue_store;
                  idx_q <= issue_mreg;
                  cnt   <= '0;
                  err_q <= (ea_next[1:0] != 2'b00);
                  state <= (ea_next[1:0] != 2'b00) ? DONE : REQ;
               end
            end
            REQ: begin
               if (beat && !last)
                  cnt <= cnt + CW'(1);
               // A flush still lets an acked beat finish; only the sequence is dropped.
               if (flush)
                  state <= IDLE;
               else if (beat && last)
                  state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign issue_ready = (state == IDLE);
   assign busy        = (state != IDLE);
   assign mem_req     = (state == REQ);
   assign mem_we      = (state == REQ) && st_q;
   assign mem_addr    = (state == REQ) ? (ea + (32'(cnt) << 2)) : 32'h0;
   assign mem_wdata   = mem_we ? mreg_rdata : 32'h0;
   assign mreg_idx    = idx_q;
   assign mreg_elem   = cnt;
   assign mreg_we     = beat && !st_q;
   assign mreg_wdata  = mreg_we ? mem_rdata : 32'h0;
   // A flush landing on the completion cycle suppresses the pulse.
   assign done        = (state == DONE) && !flush;
   assign err         = (state == DONE) && !flush && err_q;

endmodule

// File: tb/tb_mtx_ls_seq.sv
// Scoreboard bench for mtx_ls_seq: stimulus pushes expected beats/completions, a monitor pops on each ack and done.
module tb_mtx_ls_seq;
   localparam int ELEMS = 16;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          issue_valid, issue_ready, issue_store;
   logic [31:0]   issue_base, issue_imm;
   logic [2:0]    issue_mreg;
   logic          flush;
   logic          mem_req, mem_we, mem_ack;
   logic [31:0]   mem_addr, mem_wdata, mem_rdata;
   logic [2:0]    mreg_idx;
   logic [CW-1:0] mreg_elem;
   logic [31:0]   mreg_rdata, mreg_wdata;
   logic          mreg_we, busy, done, err;

   typedef struct {
      logic [31:0]   addr;
      logic          we;
      logic [CW-1:0] elem;
      logic [31:0]   wdata;
   } beat_t;

   typedef struct {
      logic err;
      int   cyc;
   } done_t;

   beat_t beat_q[$];
   done_t done_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat      = 1;

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] mreg_model(input logic [2:0] idx, input logic [CW-1:0] elem);
      return 32'hC0DE0000 | (32'(idx) << 8) | 32'(elem);
   endfunction

   assign mreg_rdata = mreg_model(mreg_idx, mreg_elem);

   mtx_ls_seq #(.ELEMS(ELEMS)) dut (
      .clk        (clk),
      .rst        (rst),
      .issue_valid(issue_valid),
      .issue_ready(issue_ready),
      .issue_store(issue_store),
      .issue_base (issue_base),
      .issue_imm  (issue_imm),
      .issue_mreg (issue_mreg),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .mreg_idx   (mreg_idx),
      .mreg_elem  (mreg_elem),
      .mreg_rdata (mreg_rdata),
      .mreg_we    (mreg_we),
      .mreg_wdata (mreg_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Memory responder: acks each request after lat cycles and checks the request holds steady.
   initial begin
      int          wait_n;
      logic [31:0] held;
      wait_n    = 0;
      held      = 0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
         if (mem_req === 1'b1) begin
            if (wait_n == 0)
               held = mem_addr;
            else
               chk("addr_held", mem_addr, held);
            if (wait_n == lat - 1) begin
               mem_ack   = 1'b1;
               mem_rdata = rd_model(mem_addr);
               wait_n    = 0;
            end else begin
               wait_n++;
            end
         end else begin
            wait_n = 0;
         end
      end
   end

   // Monitor: pops expected beats on ack cycles and expected completions on done.
   initial begin
      beat_t       b;
      done_t       d;
      logic        exp_mwe;
      logic [31:0] exp_mwd;
      forever begin
         @(negedge clk);
         #1;
         if (rst !== 1'b1) begin
            if (mem_req === 1'b1 && mem_ack === 1'b1) begin
               checks++;
               if (beat_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_beat addr=%h we=%b elem=%0d", mem_addr, mem_we, mreg_elem);
               end else begin
                  b = beat_q.pop_front();
                  exp_mwe = !b.we;
                  exp_mwd = b.we ? 32'h0 : rd_model(b.addr);
                  if (mem_addr !== b.addr || mem_we !== b.we || mreg_elem !== b.elem ||
                      mem_wdata !== b.wdata || mreg_we !== exp_mwe || mreg_wdata !== exp_mwd) begin
                     failures++;
                     $display("FAIL beat actual addr=%h we=%b elem=%0d wdata=%h mreg_we=%b mreg_wdata=%h expected addr=%h we=%b elem=%0d wdata=%h mreg_we=%b mreg_wdata=%h",
                              mem_addr, mem_we, mreg_elem, mem_wdata, mreg_we, mreg_wdata,
                              b.addr, b.we, b.elem, b.wdata, exp_mwe, exp_mwd);
                  end
               end
            end else if (mreg_we !== 1'b0) begin
               checks++;
               failures++;
               $display("FAIL mreg_we_spurious actual=%b expected=0", mreg_we);
            end
            if (done === 1'b1) begin
               checks++;
               if (done_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_done err=%b cyc=%0d", err, cyc);
               end else begin
                  d = done_q.pop_front();
                  if (err !== d.err || cyc != d.cyc) begin
                     failures++;
                     $display("FAIL done actual err=%b cyc=%0d expected err=%b cyc=%0d", err, cyc, d.err, d.cyc);
                  end
               end
            end else if (err !== 1'b0) begin
               checks++;
               failures++;
               $display("FAIL err_without_done actual=%b expected=0", err);
            end
         end
      end
   end

   task automatic do_issue(input logic st, input logic [31:0] base, input logic [31:0] imm,
                           input logic [2:0] idx, input int nbeats, input bit exp_done, output int a);
      logic [31:0] ea;
      int          t;
      beat_t       b;
      ea = base + imm;
      t  = 0;
      @(negedge clk);
      while (issue_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("issue_ready_wait", {31'h0, issue_ready}, 32'h1);
      issue_valid = 1'b1;
      issue_store = st;
      issue_base  = base;
      issue_imm   = imm;
      issue_mreg  = idx;
      a = cyc;
      if (ea[1:0] != 2'b00) begin
         done_q.push_back('{err: 1'b1, cyc: a + 1});
      end else begin
         for (int i = 0; i < nbeats; i++) begin
            b.addr  = ea + 32'(4 * i);
            b.we    = st;
            b.elem  = CW'(i);
            b.wdata = st ? mreg_model(idx, CW'(i)) : 32'h0;
            beat_q.push_back(b);
         end
         if (exp_done)
            done_q.push_back('{err: 1'b0, cyc: a + 1 + ELEMS * lat});
      end
      @(negedge clk);
      issue_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      while (!(beat_q.size() == 0 && done_q.size() == 0 && issue_ready === 1'b1) && t < 500) begin
         @(negedge clk);
         #2;
         t++;
      end
      chk(name, {31'h0, (beat_q.size() == 0 && done_q.size() == 0 && issue_ready === 1'b1)}, 32'h1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_mem_req"},     {31'h0, mem_req},     32'h0);
      chk({tag, "_mem_we"},      {31'h0, mem_we},      32'h0);
      chk({tag, "_mem_addr"},    mem_addr,             32'h0);
      chk({tag, "_mem_wdata"},   mem_wdata,            32'h0);
      chk({tag, "_mreg_we"},     {31'h0, mreg_we},     32'h0);
      chk({tag, "_mreg_wdata"},  mreg_wdata,           32'h0);
      chk({tag, "_mreg_elem"},   32'(mreg_elem),       32'h0);
      chk({tag, "_mreg_idx"},    32'(mreg_idx),        32'h0);
      chk({tag, "_busy"},        {31'h0, busy},        32'h0);
      chk({tag, "_done"},        {31'h0, done},        32'h0);
      chk({tag, "_err"},         {31'h0, err},         32'h0);
      chk({tag, "_issue_ready"}, {31'h0, issue_ready}, 32'h1);
   endtask

   initial begin
      int a;
      rst         = 1'b1;
      issue_valid = 1'b0;
      issue_store = 1'b0;
      issue_base  = 32'h0;
      issue_imm   = 32'h0;
      issue_mreg  = 3'd0;
      flush       = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk_reset("rst");
      rst = 1'b0;
      @(negedge clk);
      #2;
      chk("post_rst_ready", {31'h0, issue_ready}, 32'h1);
      chk("post_rst_busy",  {31'h0, busy},        32'h0);

      // Flush while idle blocks acceptance.
      @(negedge clk);
      issue_valid = 1'b1;
      issue_base  = 32'h1000;
      flush       = 1'b1;
      @(negedge clk);
      issue_valid = 1'b0;
      flush       = 1'b0;
      #2;
      chk("idle_flush_block", {31'h0, busy}, 32'h0);

      // Load, ack every cycle, done 17 cycles after accept.
      lat = 1;
      do_issue(1'b0, 32'h1000, 32'h20, 3'd1, ELEMS, 1'b1, a);
      wait_idle("load_idle");

      // Store with negative offset, 3-cycle ack latency.
      lat = 3;
      do_issue(1'b1, 32'h2000, 32'hFFFFFFFC, 3'd3, ELEMS, 1'b1, a);
      wait_idle("store_idle");
      lat = 1;

      // Misaligned: immediate done+err, issue held through DONE is not taken.
      @(negedge clk);
      issue_valid = 1'b1;
      issue_store = 1'b0;
      issue_base  = 32'h1001;
      issue_imm   = 32'h0;
      issue_mreg  = 3'd5;
      a = cyc;
      done_q.push_back('{err: 1'b1, cyc: a + 1});
      @(negedge clk);
      #2;
      chk("misalign_no_req",   {31'h0, mem_req},     32'h0);
      chk("done_cycle_ready",  {31'h0, issue_ready}, 32'h0);
      @(negedge clk);
      issue_valid = 1'b0;
      #2;
      chk("no_accept_in_done", {31'h0, busy},        32'h0);
      wait_idle("misalign_idle");

      // Flush coincident with the elem 5 ack.
      do_issue(1'b0, 32'h3000, 32'h0, 3'd2, 6, 1'b0, a);
      while (cyc < a + 6) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #2;
      chk("flush_req_low", {31'h0, mem_req}, 32'h0);
      chk("flush_idle",    {31'h0, busy},    32'h0);
      wait_idle("flush_idle_q");

      // Address wrap after flush: new issue is accepted.
      do_issue(1'b0, 32'hFFFFFFF8, 32'h0, 3'd4, ELEMS, 1'b1, a);
      wait_idle("wrap_idle");

      // Reset in the middle of elem 7.
      do_issue(1'b0, 32'h4000, 32'h0, 3'd6, 7, 1'b0, a);
      while (cyc != a + 8) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      chk_reset("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("midrst_ready_after", {31'h0, issue_ready}, 32'h1);
      chk("midrst_busy_after",  {31'h0, busy},        32'h0);
      repeat (3) @(negedge clk);
      #2;
      chk("midrst_no_req", {31'h0, mem_req}, 32'h0);
      chk("leftover_beats", 32'(beat_q.size()), 32'h0);
      chk("leftover_dones", 32'(done_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/mtx_ls_seq.md
MTX_LS_SEQ -- requirements
Module: mtx_ls_seq

Interface
REQ-001 Parameter ELEMS, default 16: 32-bit elements per matrix transfer, range 2..256.
REQ-002 Parameter CW, default $clog2(ELEMS): element counter width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 issue_valid  in  1  decoded Mtype M_LD/M_ST offered.
REQ-006 issue_ready  out  1  sequencer accepts an issue.
REQ-007 issue_store  in  1  1 = M_ST, 0 = M_LD.
REQ-008 issue_base  in  32  rs1 value.
REQ-009 issue_imm  in  32  sign-extended immediate from the immediate generator.
REQ-010 issue_mreg  in  3  matrix register index.
REQ-011 flush  in  1  pipeline flush, abort sequence.
REQ-012 mem_req  out  1  memory request valid.
REQ-013 mem_we  out  1  1 = write.
REQ-014 mem_addr  out  32  byte address.
REQ-015 mem_wdata  out  32  store data.
REQ-016 mem_ack  in  1  request completed this cycle; load data valid.
REQ-017 mem_rdata  in  32  load data.
REQ-018 mreg_idx  out  3  latched matrix register index.
REQ-019 mreg_elem  out  CW  current element index.
REQ-020 mreg_rdata  in  32  element read data, combinational from mreg_idx/mreg_elem.
REQ-021 mreg_we  out  1  element write strobe.
REQ-022 mreg_wdata  out  32  element write data.
REQ-023 busy  out  1  stall request to pipeline.
REQ-024 done  out  1  one-cycle completion pulse.
REQ-025 err  out  1  one-cycle misalignment pulse, coincident with done.

Function
REQ-026 States SHALL be IDLE, REQ, DONE; reset state IDLE.
REQ-027 issue_ready SHALL be 1 exactly in IDLE; busy SHALL be 1 exactly in REQ or DONE.
REQ-028 Issue accepted on issue_valid & issue_ready: latch ea = issue_base + issue_imm (mod 2^32), store flag, mreg index; counter = 0.
REQ-029 If ea[1:0] != 0 at acceptance: go to DONE with err latched, no memory request; else go to REQ.
REQ-030 In REQ: mem_req = 1, mem_addr = ea + 4*counter (mod 2^32), mem_we = store flag, mreg_elem = counter.
REQ-031 mem_wdata SHALL equal mreg_rdata when mem_we = 1, else 0.
REQ-032 Request outputs SHALL stay stable until the mem_ack cycle; ack in the first request cycle is legal.
REQ-033 Load ack cycle: mreg_we = 1, mreg_wdata = mem_rdata, mreg_elem = counter, same cycle (combinational from mem_ack).
REQ-034 Ack with counter < ELEMS-1: counter increments; next request issues the following cycle (one beat per cycle max).
REQ-035 Ack with counter = ELEMS-1: go to DONE; no further mem_req.
REQ-036 DONE lasts one cycle: done = 1, err = latched flag; then IDLE. An issue in the DONE cycle SHALL NOT be accepted.
REQ-037 flush in REQ or DONE: next state IDLE, no done/err pulse; mem_req drops the next cycle.
REQ-038 flush coincident with mem_ack: the ack beat completes (load write performed), then IDLE.
REQ-039 flush in IDLE SHALL block acceptance that cycle.
REQ-040 mreg_we SHALL never assert for stores, outside REQ, or without mem_ack.

Reset
REQ-041 On rst: state IDLE, counter 0, latched ea/flags/index 0, asynchronously.
REQ-042 Output values during and after reset: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mreg_we 0, mreg_wdata 0, mreg_elem 0, mreg_idx 0, busy 0, done 0, err 0, issue_ready 1.
REQ-043 rst mid-sequence SHALL abort immediately without done; the remaining beats are never issued.

Verification
REQ-044 Load, base 0x1000, imm 0x20, ack every cycle -> addrs 0x1020..0x105C step 4, 16 mreg_we, done 17 cycles after accept.
REQ-045 Store, base 0x2000, imm -4 (0xFFFFFFFC), ack 3-cycle latency -> first addr 0x1FFC, address held until ack, mem_wdata = mreg_rdata per elem.
REQ-046 base 0x1001, imm 0 -> no mem_req, done=err=1 one cycle after accept.
REQ-047 base 0xFFFFFFF8, imm 0 -> addr wraps to 0x00000000 at elem 2.
REQ-048 flush with ack at elem 5 -> elem 5 written, mem_req low next cycle, no done; new issue accepted afterward.
REQ-049 rst asserted at elem 7 -> all outputs reset values same cycle, issue_ready 1 after release.
